// File: rtl/ivalu_wb_buffer.sv
// Writeback skid FIFO between the non-stallable vector-integer ALU and the shared
// register-file / ROB completion port; stalls issue early so in-flight results always fit.
module ivalu_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int SLACK = 2
) (
  input  logic                     core_clock_i,
  input  logic                     core_reset_i,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic                     in_wb_valid_i,
  input  logic [31:0]              in_result_i,
  input  logic [5:0]               in_dest_i,
  input  logic [4:0]               in_rob_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_result_o,
  output logic [5:0]               out_dest_o,
  output logic [4:0]               out_rob_o,
  output logic                     out_wb_en_o,
  output logic                     issue_stall_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] STALL_TH = (PW+1)'(DEPTH - SLACK + 1);

  logic [31:0]   result_q [DEPTH];
  logic [5:0]    dest_q   [DEPTH];
  logic [4:0]    rob_q    [DEPTH];
  logic          wb_q     [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          overflow_q;
  logic          full;
  logic          fire;
  logic          push;
  logic          drop;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign count  = wr_ptr - rd_ptr;
  assign full   = (count == PW'(DEPTH));
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  assign out_valid_o = (count != '0);
  assign fire        = out_valid_o & out_ready_i;
  // A dequeue in the same edge frees the slot, so a full FIFO still accepts.
  assign push        = in_valid_i & (~full | fire);
  assign drop        = in_valid_i & full & ~fire;

  assign out_result_o = result_q[rd_idx];
  assign out_dest_o   = dest_q[rd_idx];
  assign out_rob_o    = rob_q[rd_idx];
  assign out_wb_en_o  = wb_q[rd_idx];

  assign issue_stall_o = (({1'b0, count} + {{PW{1'b0}}, in_valid_i}) >= STALL_TH);
  assign count_o       = count;
  assign overflow_o    = overflow_q;

  always_ff @(posedge core_clock_i or negedge core_reset_i) begin
    if (!core_reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        result_q[i] <= '0;
        dest_q[i]   <= '0;
        rob_q[i]    <= '0;
        wb_q[i]     <= 1'b0;
      end
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        result_q[wr_idx] <= in_result_i;
        dest_q[wr_idx]   <= in_dest_i;
        rob_q[wr_idx]    <= in_rob_i;
        wb_q[wr_idx]     <= in_wb_valid_i;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (fire) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ivalu_wb_buffer.sv
// Scoreboard bench for ivalu_wb_buffer: stimulus pushes expected entries, a negedge
// monitor pops and compares them whenever the writeback handshake fires.
module tb_ivalu_wb_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_wb;
  logic [31:0] in_result;
  logic [5:0]  in_dest;
  logic [4:0]  in_rob;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_dest;
  logic [4:0]  out_rob;
  logic        out_wb_en;
  logic        issue_stall;
  logic [2:0]  count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [43:0] exp_q[$];

  always #5 clk = ~clk;

  ivalu_wb_buffer #(.DEPTH(DEPTH), .SLACK(2)) dut (
    .core_clock_i  (clk),
    .core_reset_i  (rst_n),
    .flush_i       (flush),
    .in_valid_i    (in_valid),
    .in_wb_valid_i (in_wb),
    .in_result_i   (in_result),
    .in_dest_i     (in_dest),
    .in_rob_i      (in_rob),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_result_o  (out_result),
    .out_dest_o    (out_dest),
    .out_rob_o     (out_rob),
    .out_wb_en_o   (out_wb_en),
    .issue_stall_o (issue_stall),
    .count_o       (count),
    .overflow_o    (overflow)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ALU result for the coming edge; queue it only if it should be accepted.
  task automatic drive(input logic [31:0] r, input logic [5:0] d, input logic [4:0] rb,
                       input logic wb, input bit keep);
    in_valid  = 1'b1;
    in_result = r;
    in_dest   = d;
    in_rob    = rb;
    in_wb     = wb;
    if (keep) exp_q.push_back({r, d, rb, wb});
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %0h expected none",
                 {out_result, out_dest, out_rob, out_wb_en});
      end else begin
        chk("wb_entry", {20'h0, out_result, out_dest, out_rob, out_wb_en}, {20'h0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int mcount;
    int enq_total;
    bit v;
    bit r;
    bit f;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_wb = 1'b0;
    in_result = '0; in_dest = '0; in_rob = '0; out_ready = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", issue_stall, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data", {out_result, out_dest, out_rob, out_wb_en}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single result passes through with one cycle of latency.
    out_ready = 1'b1;
    drive(32'hDEADBEEF, 6'd5, 5'd3, 1'b1, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_count1", count, 1);
    chk("t2_valid", out_valid, 1);
    step();
    chk("t2_count0", count, 0);
    chk("t2_valid0", out_valid, 0);

    // Fill with the port blocked; stall must lead occupancy.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000_0000 + i, 6'(10 + i), 5'(i + 1), 1'b1, 1);
      #1;
      chk("t3_stall", issue_stall, (i >= 2) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("t3_count4", count, 4);
    chk("t3_stall_full", issue_stall, 1);

    // Full with a simultaneous dequeue accepts; without one it drops.
    out_ready = 1'b1;
    drive(32'hCAFE_0001, 6'd20, 5'd9, 1'b1, 1);
    step();
    chk("t4_count_keep", count, 4);
    chk("t4_no_overflow", overflow, 0);
    out_ready = 1'b0;
    drive(32'hBAD0_BAD0, 6'd21, 5'd10, 1'b1, 0);
    step();
    in_valid = 1'b0;
    chk("t4_overflow", overflow, 1);
    chk("t4_count_drop", count, 4);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid) break;
      step();
    end
    chk("t4_drained", count, 0);
    chk("t4_queue_empty", exp_q.size(), 0);

    // ROB-only completion (no register write).
    drive(32'h0000_1234, 6'd0, 5'd7, 1'b0, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_valid", out_valid, 1);
    chk("t5_wb_en", out_wb_en, 0);
    chk("t5_rob", out_rob, 7);
    step();
    chk("t5_count0", count, 0);

    // Flush discards held entries and the result arriving with it.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h2000_0000 + i, 6'(30 + i), 5'(20 + i), 1'b1, 1);
      step();
    end
    drive(32'h3333_3333, 6'd40, 5'd30, 1'b1, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    chk("t6_count", count, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_overflow_kept", overflow, 1);

    mcount = 0;
    enq_total = 0;
    for (int c = 0; c < 30; c++) begin
      v = ($urandom_range(0, 3) != 0) && (mcount < DEPTH);
      r = ($urandom_range(0, 3) != 0);
      f = r && (mcount > 0);
      out_ready = r;
      if (v) begin
        drive($urandom, 6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 1);
        enq_total++;
      end else begin
        in_valid = 1'b0;
      end
      mcount = mcount + (v ? 1 : 0) - (f ? 1 : 0);
      step();
      chk("t6_rand_count", count, mcount);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (!out_valid) break;
      step();
    end
    chk("t6_rand_drained", count, 0);
    chk("t6_rand_queue_empty", exp_q.size(), 0);
    if (enq_total <= 2 * DEPTH) $display("note: only %0d random enqueues", enq_total);

    // Asynchronous reset with entries held clears state before any edge.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h4000_0000 + i, 6'(50 + i), 5'(i), 1'b1, 1);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_valid", out_valid, 0);
    chk("t1_count", count, 0);
    chk("t1_overflow", overflow, 0);
    chk("t1_stall", issue_stall, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t1_count_after", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
